// File: rtl/clk_div_prog.sv
// Programmable N-channel clock divider: per-channel runtime ratio with
// glitch-free apply at period boundaries, registered level and strobe outputs.
module clk_div_prog #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             iClkIN,
    input  logic             reset,
    input  logic             iEn,
    input  logic             iSync,
    input  logic             iWr,
    input  logic [CH_W-1:0]  iCh,
    input  logic [CNT_W-1:0] iDiv,
    output logic [N_CH-1:0]  oDiv,
    output logic [N_CH-1:0]  oStb,
    output logic [N_CH-1:0]  oPend
);

    logic [CNT_W-1:0] act_q [N_CH];
    logic [CNT_W-1:0] act_d [N_CH];
    logic [CNT_W-1:0] pnd_q [N_CH];
    logic [CNT_W-1:0] pnd_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  div_q, div_d;
    logic [N_CH-1:0]  stb_q, stb_d;
    logic [N_CH-1:0]  pend_q, pend_d;

    always_comb begin
        // NOTE: every next-state value starts as a copy of its register so no
        // branch can leave it unassigned and infer a latch.
        div_d  = div_q;
        stb_d  = stb_q;
        pend_d = pend_q;
        for (int k = 0; k < N_CH; k++) begin
            logic wr_hit;
            logic wrap;
            act_d[k] = act_q[k];
            pnd_d[k] = pnd_q[k];
            cnt_d[k] = cnt_q[k];
            wr_hit   = iWr && (int'(iCh) == k);
            wrap     = (cnt_q[k] == act_q[k] - 1'b1);

            if (iSync) begin
                // A write landing with iSync is taken directly as the new ratio.
                if (wr_hit) begin
                    act_d[k] = iDiv;
                    pnd_d[k] = iDiv;
                end else if (pend_q[k]) begin
                    act_d[k] = pnd_q[k];
                end
                pend_d[k] = 1'b0;
                cnt_d[k]  = '0;
                div_d[k]  = 1'b0;
                stb_d[k]  = 1'b0;
            end else begin
                if (act_q[k] < CNT_W'(2)) begin
                    // Ratio 0/1 means stopped; a pending ratio applies at once.
                    cnt_d[k] = '0;
                    div_d[k] = 1'b0;
                    stb_d[k] = 1'b0;
                    if (pend_q[k]) begin
                        act_d[k]  = pnd_q[k];
                        pend_d[k] = 1'b0;
                    end
                end else if (iEn) begin
                    div_d[k] = (cnt_q[k] < (act_q[k] >> 1));
                    stb_d[k] = wrap;
                    cnt_d[k] = wrap ? '0 : cnt_q[k] + 1'b1;
                    if (wrap && pend_q[k]) begin
                        act_d[k]  = pnd_q[k];
                        pend_d[k] = 1'b0;
                    end
                end
                // Applied from the old pending value first, so a write on the
                // apply edge survives as the next pending ratio.
                if (wr_hit) begin
                    pnd_d[k]  = iDiv;
                    pend_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClkIN) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                // NOTE: state registers use non-blocking assignment so every
                // flop samples the pre-edge values of the others.
                act_q[k] <= CNT_W'(1) << (k + 1);
                pnd_q[k] <= CNT_W'(1) << (k + 1);
                cnt_q[k] <= '0;
            end
            div_q  <= '0;
            stb_q  <= '0;
            pend_q <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                act_q[k] <= act_d[k];
                pnd_q[k] <= pnd_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            div_q  <= div_d;
            stb_q  <= stb_d;
            pend_q <= pend_d;
        end
    end

    assign oDiv  = div_q;
    assign oStb  = stb_q;
    assign oPend = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios then randomized
// traffic, all compared cycle by cycle against a period/phase reference model.
module tb_clk_div_prog;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, en, sync, wr;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] dv;
    logic [N_CH-1:0]  o_div, o_stb, o_pend;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: ratio, queued ratio, and position within the current period.
    int ref_ratio [N_CH];
    int ref_queued[N_CH];
    int ref_phase [N_CH];
    bit ref_has_q [N_CH];
    bit ref_level [N_CH];
    bit ref_end   [N_CH];

    clk_div_prog #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .iClkIN(clk),
        .reset (rst),
        .iEn   (en),
        .iSync (sync),
        .iWr   (wr),
        .iCh   (ch),
        .iDiv  (dv),
        .oDiv  (o_div),
        .oStb  (o_stb),
        .oPend (o_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic ref_defaults();
        for (int k = 0; k < N_CH; k++) begin
            ref_ratio[k]  = 2 ** (k + 1);
            ref_queued[k] = 2 ** (k + 1);
            ref_phase[k]  = 0;
            ref_has_q[k]  = 1'b0;
            ref_level[k]  = 1'b0;
            ref_end[k]    = 1'b0;
        end
    endtask

    // One source-clock edge of the specification's per-channel rules.
    task automatic ref_edge();
        if (rst) begin
            ref_defaults();
            return;
        end
        for (int k = 0; k < N_CH; k++) begin
            bit written;
            written = wr && (int'(ch) == k);
            if (sync) begin
                if (written) ref_ratio[k] = int'(dv);
                else if (ref_has_q[k]) ref_ratio[k] = ref_queued[k];
                if (written) ref_queued[k] = int'(dv);
                ref_has_q[k] = 1'b0;
                ref_phase[k] = 0;
                ref_level[k] = 1'b0;
                ref_end[k]   = 1'b0;
            end else begin
                if (ref_ratio[k] <= 1) begin
                    ref_phase[k] = 0;
                    ref_level[k] = 1'b0;
                    ref_end[k]   = 1'b0;
                    if (ref_has_q[k]) begin
                        ref_ratio[k] = ref_queued[k];
                        ref_has_q[k] = 1'b0;
                    end
                end else if (en) begin
                    bit last;
                    last = (ref_phase[k] + 1 == ref_ratio[k]);
                    ref_level[k] = (2 * ref_phase[k] < ref_ratio[k] - (ref_ratio[k] % 2));
                    ref_end[k]   = last;
                    ref_phase[k] = (ref_phase[k] + 1) % ref_ratio[k];
                    if (last && ref_has_q[k]) begin
                        ref_ratio[k] = ref_queued[k];
                        ref_has_q[k] = 1'b0;
                    end
                end
                if (written) begin
                    ref_queued[k] = int'(dv);
                    ref_has_q[k]  = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        logic [N_CH-1:0] e_div, e_stb, e_pend;
        ref_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < N_CH; k++) begin
            e_div[k]  = ref_level[k];
            e_stb[k]  = ref_end[k];
            e_pend[k] = ref_has_q[k];
        end
        check("oDiv", 32'(o_div), 32'(e_div));
        check("oStb", 32'(o_stb), 32'(e_stb));
        check("oPend", 32'(o_pend), 32'(e_pend));
    endtask

    task automatic write(input int c, input int d);
        wr = 1'b1;
        ch = CH_W'(c);
        dv = CNT_W'(d);
        tick();
        wr = 1'b0;
    endtask

    initial begin
        int n_div0, n_div3, n_stb1, n_stb0;
        bit found;
        ref_defaults();
        rst = 1'b1; en = 1'b0; sync = 1'b0; wr = 1'b0; ch = '0; dv = '0;
        tick();
        tick();
        check("reset_div", 32'(o_div), 32'd0);
        check("reset_stb", 32'(o_stb), 32'd0);
        check("reset_pend", 32'(o_pend), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        n_div0 = 0; n_div3 = 0; n_stb1 = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) check("first_edge_div", 32'(o_div), 32'hF);
            n_div0 += int'(o_div[0]);
            n_div3 += int'(o_div[3]);
            n_stb1 += int'(o_stb[1]);
        end
        check("def_div0_high", n_div0, 16);
        check("def_div3_high", n_div3, 16);
        check("def_stb1_count", n_stb1, 8);

        // ch0 to /5: pending until the current /2 period wraps.
        write(0, 5);
        check("ch0_pending", 32'(o_pend[0]), 32'd1);
        tick();
        check("ch0_applied", 32'(o_pend[0]), 32'd0);
        n_stb0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_stb0 += int'(o_stb[0]);
        end
        check("ch0_stb_per5", n_stb0, 4);

        // ch2: last write wins, then a write exactly on a wrap edge.
        write(2, 7);
        write(2, 3);
        for (int i = 0; i < 20; i++) tick();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (ref_ratio[2] >= 2 && ref_phase[2] == ref_ratio[2] - 1) found = 1'b1;
            else tick();
        end
        check("ch2_wrap_found", 32'(found), 32'd1);
        write(2, 4);
        check("ch2_wrap_write_pending", 32'(o_pend[2]), 32'd1);
        for (int i = 0; i < 12; i++) tick();

        // ch1 stopped, then restarted at /3.
        write(1, 0);
        for (int i = 0; i < 12; i++) tick();
        check("ch1_stopped", 32'({o_div[1], o_stb[1]}), 32'd0);
        write(1, 3);
        for (int i = 0; i < 10; i++) tick();

        // Freeze, then resume.
        en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Pending ch3 /6 applied by iSync, then reset mid-count.
        write(3, 6);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_div_zero", 32'(o_div), 32'd0);
        check("sync_pend_clear", 32'(o_pend), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset2_div", 32'(o_div), 32'd0);
        check("reset2_pend", 32'(o_pend), 32'd0);
        for (int i = 0; i < 20; i++) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            sync = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 9) != 0);
            wr   = ($urandom_range(0, 7) == 0);
            ch   = CH_W'($urandom);
            dv   = CNT_W'($urandom_range(0, 12));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
